id_operand_stage: RTL and testbench

// Decode/operand-fetch stage of the 5-stage MIPS pipeline. Holds the IF/ID register and drives regfile read addresses.

---
 rtl/id_operand_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_operand_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ============================================================================
// Module   : id_operand_stage
// Purpose  : MIPS decode/operand-fetch stage. IF/ID register, MEM/WB operand
//            bypass, RAW hazard detection and ID/EX register load.
//            Macro ID_WB_BYPASS_EN enables the WB bypass path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int R_WIDTH = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               if_valid_d,
    input  logic [31:0]        if_instr_d,
    input  logic [WIDTH-1:0]   if_pc_d,
    input  logic               flush_d,
    input  logic               ex_stall_d,
    input  logic               ex_valid_d,
    input  logic               ex_regwrite_d,
    input  logic [R_WIDTH-1:0] ex_write_reg_d,
    input  logic               mem_regwrite_d,
    input  logic [R_WIDTH-1:0] mem_write_reg_d,
    input  logic [WIDTH-1:0]   mem_result_d,
    input  logic               wb_regwrite_d,
    input  logic [R_WIDTH-1:0] wb_write_reg_d,
    input  logic [WIDTH-1:0]   wb_write_data_d,
    output logic [R_WIDTH-1:0] rf_read_reg1_q,
    output logic [R_WIDTH-1:0] rf_read_reg2_q,
    input  logic [WIDTH-1:0]   rf_read_data1_d,
    input  logic [WIDTH-1:0]   rf_read_data2_d,
    output logic               stall_q,
    output logic               idex_valid_q,
    output logic [WIDTH-1:0]   idex_pc_q,
    output logic [31:0]        idex_instr_q,
    output logic [WIDTH-1:0]   idex_rs_data_q,
    output logic [WIDTH-1:0]   idex_rt_data_q,
    output logic [WIDTH-1:0]   idex_imm_q,
    output logic [R_WIDTH-1:0] idex_rd_q,
    output logic [CNT_W-1:0]   stall_cnt_q
);

`ifdef ID_WB_BYPASS_EN
    localparam logic c_wb_bypass = 1'b1;
`else
    localparam logic c_wb_bypass = 1'b0;
`endif

    logic               ifid_valid_q, ifid_valid_d;
    logic [31:0]        ifid_instr_q, ifid_instr_d;
    logic [WIDTH-1:0]   ifid_pc_q,    ifid_pc_d;

    logic               idex_valid_d;
    logic [WIDTH-1:0]   idex_pc_d;
    logic [31:0]        idex_instr_d;
    logic [WIDTH-1:0]   idex_rs_data_d;
    logic [WIDTH-1:0]   idex_rt_data_d;
    logic [WIDTH-1:0]   idex_imm_d;
    logic [R_WIDTH-1:0] idex_rd_d;
    logic [CNT_W-1:0]   stall_cnt_d;

    logic [R_WIDTH-1:0] w_rs;
    logic [R_WIDTH-1:0] w_rt;
    logic [WIDTH-1:0]   w_rs_data;
    logic [WIDTH-1:0]   w_rt_data;
    logic               w_ex_hit;
    logic               w_wb_hit;
    logic               w_haz;

    // MEM wins over WB; WB is only consulted when the bypass is built in.
    function automatic logic [WIDTH-1:0] resolve(
        input logic [R_WIDTH-1:0] idx,
        input logic [WIDTH-1:0]   rf_data,
        input logic               mem_we,
        input logic [R_WIDTH-1:0] mem_reg,
        input logic [WIDTH-1:0]   mem_data,
        input logic               wb_we,
        input logic [R_WIDTH-1:0] wb_reg,
        input logic [WIDTH-1:0]   wb_data
    );
        if (idx == '0)                         return '0;
        else if (mem_we && idx == mem_reg)     return mem_data;
        else if (c_wb_bypass && wb_we && idx == wb_reg) return wb_data;
        else                                   return rf_data;
    endfunction

    function automatic logic wb_only(
        input logic [R_WIDTH-1:0] idx,
        input logic               mem_we,
        input logic [R_WIDTH-1:0] mem_reg,
        input logic               wb_we,
        input logic [R_WIDTH-1:0] wb_reg
    );
        return (idx != '0) && wb_we && (idx == wb_reg) && !(mem_we && idx == mem_reg);
    endfunction

    assign w_rs           = ifid_instr_q[21 +: R_WIDTH];
    assign w_rt           = ifid_instr_q[16 +: R_WIDTH];
    assign rf_read_reg1_q = w_rs;
    assign rf_read_reg2_q = w_rt;

    assign w_rs_data = resolve(w_rs, rf_read_data1_d, mem_regwrite_d, mem_write_reg_d,
                               mem_result_d, wb_regwrite_d, wb_write_reg_d, wb_write_data_d);
    assign w_rt_data = resolve(w_rt, rf_read_data2_d, mem_regwrite_d, mem_write_reg_d,
                               mem_result_d, wb_regwrite_d, wb_write_reg_d, wb_write_data_d);

    // rt is matched for every opcode, even where it is not a source.
    assign w_ex_hit = ifid_valid_q && ex_valid_d && ex_regwrite_d && (ex_write_reg_d != '0)
                      && ((ex_write_reg_d == w_rs) || (ex_write_reg_d == w_rt));
    // Without the WB bypass, wait one cycle for the regfile write to land.
    assign w_wb_hit = ifid_valid_q && !c_wb_bypass
                      && (wb_only(w_rs, mem_regwrite_d, mem_write_reg_d, wb_regwrite_d, wb_write_reg_d)
                       || wb_only(w_rt, mem_regwrite_d, mem_write_reg_d, wb_regwrite_d, wb_write_reg_d));
    assign w_haz    = w_ex_hit || w_wb_hit;

    assign stall_q  = (w_haz || ex_stall_d) && !flush_d;

    always_comb begin
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        idex_valid_d   = idex_valid_q;
        idex_pc_d      = idex_pc_q;
        idex_instr_d   = idex_instr_q;
        idex_rs_data_d = idex_rs_data_q;
        idex_rt_data_d = idex_rt_data_q;
        idex_imm_d     = idex_imm_q;
        idex_rd_d      = idex_rd_q;
        stall_cnt_d    = stall_cnt_q;

        if (flush_d) begin
            ifid_valid_d = 1'b0;
            idex_valid_d = 1'b0;
        end else if (ex_stall_d) begin
            idex_valid_d = idex_valid_q;
        end else if (w_haz) begin
            idex_valid_d = 1'b0;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            idex_valid_d   = ifid_valid_q;
            idex_pc_d      = ifid_pc_q;
            idex_instr_d   = ifid_instr_q;
            idex_rs_data_d = w_rs_data;
            idex_rt_data_d = w_rt_data;
            idex_imm_d     = {{(WIDTH-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
            idex_rd_d      = ifid_instr_q[11 +: R_WIDTH];
            ifid_valid_d   = if_valid_d;
            ifid_instr_d   = if_instr_d;
            ifid_pc_d      = if_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_q      <= '0;
            idex_valid_q   <= 1'b0;
            idex_pc_q      <= '0;
            idex_instr_q   <= '0;
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rd_q      <= '0;
            stall_cnt_q    <= '0;
        end else begin
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            idex_valid_q   <= idex_valid_d;
            idex_pc_q      <= idex_pc_d;
            idex_instr_q   <= idex_instr_d;
            idex_rs_data_q <= idex_rs_data_d;
            idex_rt_data_q <= idex_rt_data_d;
            idex_imm_q     <= idex_imm_d;
            idex_rd_q      <= idex_rd_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_operand_stage.sv
// ============================================================================
// Module   : tb_id_operand_stage
// Purpose  : Directed self-checking bench for id_operand_stage, with a small
//            regfile model written by the WB inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_operand_stage;

    localparam int WIDTH   = 32;
    localparam int R_WIDTH = 5;
    localparam int CNT_W   = 4;

    localparam logic [31:0] c_addi_1_0_5 = 32'h2001_0005;
    localparam logic [31:0] c_add_3_1_1  = 32'h0021_1820;
    localparam logic [31:0] c_add_4_2_2  = 32'h0042_2020;
    localparam logic [31:0] c_add_5_0_0  = 32'h0000_2820;
    localparam logic [31:0] c_add_6_4_0  = 32'h0080_3020;

    logic               clk = 1'b0;
    logic               rst;
    logic               if_valid;
    logic [31:0]        if_instr;
    logic [WIDTH-1:0]   if_pc;
    logic               flush;
    logic               ex_stall;
    logic               ex_valid;
    logic               ex_regwrite;
    logic [R_WIDTH-1:0] ex_write_reg;
    logic               mem_regwrite;
    logic [R_WIDTH-1:0] mem_write_reg;
    logic [WIDTH-1:0]   mem_result;
    logic               wb_regwrite;
    logic [R_WIDTH-1:0] wb_write_reg;
    logic [WIDTH-1:0]   wb_write_data;
    logic [R_WIDTH-1:0] rf_read_reg1;
    logic [R_WIDTH-1:0] rf_read_reg2;
    logic [WIDTH-1:0]   rf_read_data1;
    logic [WIDTH-1:0]   rf_read_data2;
    logic               stall;
    logic               idex_valid;
    logic [WIDTH-1:0]   idex_pc;
    logic [31:0]        idex_instr;
    logic [WIDTH-1:0]   idex_rs_data;
    logic [WIDTH-1:0]   idex_rt_data;
    logic [WIDTH-1:0]   idex_imm;
    logic [R_WIDTH-1:0] idex_rd;
    logic [CNT_W-1:0]   stall_cnt;

    logic [WIDTH-1:0]   regs [32];
    int                 n_checks = 0;
    int                 n_fails  = 0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
    end

    always @(posedge clk) begin
        if (wb_regwrite && wb_write_reg != '0) regs[wb_write_reg] <= wb_write_data;
    end

    assign rf_read_data1 = regs[rf_read_reg1];
    assign rf_read_data2 = regs[rf_read_reg2];

    id_operand_stage #(.WIDTH(WIDTH), .R_WIDTH(R_WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_valid_d      (if_valid),
        .if_instr_d      (if_instr),
        .if_pc_d         (if_pc),
        .flush_d         (flush),
        .ex_stall_d      (ex_stall),
        .ex_valid_d      (ex_valid),
        .ex_regwrite_d   (ex_regwrite),
        .ex_write_reg_d  (ex_write_reg),
        .mem_regwrite_d  (mem_regwrite),
        .mem_write_reg_d (mem_write_reg),
        .mem_result_d    (mem_result),
        .wb_regwrite_d   (wb_regwrite),
        .wb_write_reg_d  (wb_write_reg),
        .wb_write_data_d (wb_write_data),
        .rf_read_reg1_q  (rf_read_reg1),
        .rf_read_reg2_q  (rf_read_reg2),
        .rf_read_data1_d (rf_read_data1),
        .rf_read_data2_d (rf_read_data2),
        .stall_q         (stall),
        .idex_valid_q    (idex_valid),
        .idex_pc_q       (idex_pc),
        .idex_instr_q    (idex_instr),
        .idex_rs_data_q  (idex_rs_data),
        .idex_rt_data_q  (idex_rt_data),
        .idex_imm_q      (idex_imm),
        .idex_rd_q       (idex_rd),
        .stall_cnt_q     (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_valid = 0; ex_regwrite = 0; ex_write_reg = '0;
        mem_regwrite = 0; mem_write_reg = '0; mem_result = '0;
        wb_regwrite = 0; wb_write_reg = '0; wb_write_data = '0;
    endtask

    initial begin
        int exp_cnt;
        rst = 1; if_valid = 0; if_instr = '0; if_pc = '0; flush = 0; ex_stall = 0;
        clear_fwd();

        // Reset held for two cycles
        tick(); tick();
        rst = 0; #1;
        check_eq("rst_idex_valid", 32'(idex_valid), 32'd0);
        check_eq("rst_stall_cnt",  32'(stall_cnt),  32'd0);
        check_eq("rst_stall",      32'(stall),      32'd0);
        check_eq("rst_idex_pc",    idex_pc,         32'd0);

        // addi $1,$0,5 followed by dependent add $3,$1,$1
        if_valid = 1; if_instr = c_addi_1_0_5; if_pc = 32'h100;
        tick();
        if_instr = c_add_3_1_1; if_pc = 32'h104;
        tick();
        check_eq("addi_valid", 32'(idex_valid), 32'd1);
        check_eq("addi_pc",    idex_pc,         32'h100);
        check_eq("addi_imm",   idex_imm,        32'd5);
        check_eq("addi_rs",    idex_rs_data,    32'd0);
        check_eq("add_rdaddr1", 32'(rf_read_reg1), 32'd1);
        ex_valid = 1; ex_regwrite = 1; ex_write_reg = 5'd1;
        if_instr = 32'h0; if_pc = 32'h108;
        #1;
        check_eq("raw_stall", 32'(stall), 32'd1);
        tick();
        check_eq("raw_bubble", 32'(idex_valid), 32'd0);
        check_eq("raw_cnt",    32'(stall_cnt),  32'd1);
        clear_fwd();
        mem_regwrite = 1; mem_write_reg = 5'd1; mem_result = 32'd5;
        if_valid = 0;
        #1;
        check_eq("raw_unstall", 32'(stall), 32'd0);
        tick();
        check_eq("add_valid", 32'(idex_valid), 32'd1);
        check_eq("add_rs",    idex_rs_data,    32'd5);
        check_eq("add_rt",    idex_rt_data,    32'd5);
        check_eq("add_rd",    32'(idex_rd),    32'd3);
        check_eq("add_pc",    idex_pc,         32'h104);
        check_eq("add_cnt",   32'(stall_cnt),  32'd1);
        clear_fwd();

        // Downstream stall holds ID/EX and does not count
        ex_stall = 1; if_valid = 1; if_instr = c_add_4_2_2; if_pc = 32'h200;
        #1;
        check_eq("exst_stall", 32'(stall), 32'd1);
        tick();
        check_eq("exst_hold_pc",    idex_pc,         32'h104);
        check_eq("exst_hold_valid", 32'(idex_valid), 32'd1);
        check_eq("exst_cnt",        32'(stall_cnt),  32'd1);
        ex_stall = 0;
        tick();
        check_eq("invalid_ifid_bubble", 32'(idex_valid), 32'd0);

        // MEM and WB both write $2: MEM result wins
        if_valid = 0;
        mem_regwrite = 1; mem_write_reg = 5'd2; mem_result = 32'd7;
        wb_regwrite = 1; wb_write_reg = 5'd2; wb_write_data = 32'd9;
        #1;
        check_eq("memwb_nostall", 32'(stall), 32'd0);
        tick();
        check_eq("memwb_rs", idex_rs_data, 32'd7);
        check_eq("memwb_rt", idex_rt_data, 32'd7);
        check_eq("memwb_pc", idex_pc,      32'h200);
        clear_fwd();

        // Reading $0 while MEM and EX target register 0
        if_valid = 1; if_instr = c_add_5_0_0; if_pc = 32'h300;
        tick();
        if_valid = 0;
        mem_regwrite = 1; mem_write_reg = 5'd0; mem_result = 32'hFFFF_FFFF;
        ex_valid = 1; ex_regwrite = 1; ex_write_reg = 5'd0;
        #1;
        check_eq("r0_nostall", 32'(stall), 32'd0);
        tick();
        check_eq("r0_valid", 32'(idex_valid), 32'd1);
        check_eq("r0_rs",    idex_rs_data,    32'd0);
        check_eq("r0_rt",    idex_rt_data,    32'd0);
        clear_fwd();

        // Hazard and flush in the same cycle
        if_valid = 1; if_instr = c_add_3_1_1; if_pc = 32'h400;
        tick();
        ex_valid = 1; ex_regwrite = 1; ex_write_reg = 5'd1;
        flush = 1; if_pc = 32'h404;
        #1;
        check_eq("flush_stall", 32'(stall), 32'd0);
        tick();
        check_eq("flush_idex_valid", 32'(idex_valid), 32'd0);
        check_eq("flush_cnt",        32'(stall_cnt),  32'd1);
        flush = 0; if_valid = 0;
        #1;
        check_eq("flush_ifid_clear", 32'(stall), 32'd0);
        tick();
        check_eq("flush_after_valid", 32'(idex_valid), 32'd0);
        clear_fwd();

        // WB-only match on $4
        if_valid = 1; if_instr = c_add_6_4_0; if_pc = 32'h500;
        tick();
        if_valid = 0;
        wb_regwrite = 1; wb_write_reg = 5'd4; wb_write_data = 32'h1234;
        #1;
`ifdef ID_WB_BYPASS_EN
        exp_cnt = 1;
        check_eq("wb_stall", 32'(stall), 32'd0);
        tick();
`else
        exp_cnt = 2;
        check_eq("wb_stall", 32'(stall), 32'd1);
        tick();
        check_eq("wb_bubble", 32'(idex_valid), 32'd0);
        wb_regwrite = 0;
        #1;
        check_eq("wb_unstall", 32'(stall), 32'd0);
        tick();
`endif
        check_eq("wb_valid", 32'(idex_valid), 32'd1);
        check_eq("wb_rs",    idex_rs_data,    32'h1234);
        check_eq("wb_cnt",   32'(stall_cnt),  32'(exp_cnt));
        clear_fwd();

        // Counter saturation under a long hazard
        if_valid = 1; if_instr = c_add_3_1_1; if_pc = 32'h600;
        tick();
        if_valid = 0;
        ex_valid = 1; ex_regwrite = 1; ex_write_reg = 5'd1;
        repeat (20) tick();
        check_eq("sat_cnt",   32'(stall_cnt), 32'd15);
        check_eq("sat_stall", 32'(stall),     32'd1);

        // Reset in the middle of the stall
        rst = 1;
        tick();
        check_eq("midrst_cnt",   32'(stall_cnt),  32'd0);
        check_eq("midrst_valid", 32'(idex_valid), 32'd0);
        check_eq("midrst_pc",    idex_pc,         32'd0);
        check_eq("midrst_stall", 32'(stall),      32'd0);
        rst = 0;
        tick();
        check_eq("postrst_valid", 32'(idex_valid), 32'd0);
        check_eq("postrst_cnt",   32'(stall_cnt),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
